// File: rtl/rectangle128_keysched.sv
// RECTANGLE-128 key schedule: expands a 128-bit master key into 26 64-bit subkeys.
// Optional restart-in-flight behaviour enabled by defining RECTANGLE128_KS_RESTART_EN.
module rectangle128_keysched (
  input  logic         Clk,
  input  logic         flush,
  input  logic         start,
  input  logic [127:0] Key,
  output logic         busy,
  output logic         done,
  output logic         WE,
  output logic [4:0]   WAddr,
  output logic [63:0]  KeyOut
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] r0, r1, r2, r3;
  logic [31:0] s0, s1, s2, s3;
  logic [31:0] n0, n1, n2, n3;
  logic [4:0]  rc, rc_nxt;
  logic [4:0]  cnt;
  logic [3:0]  nib;
  logic        load, step;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h6;  4'h1: y = 4'h5;  4'h2: y = 4'hC;  4'h3: y = 4'hA;
      4'h4: y = 4'h1;  4'h5: y = 4'hE;  4'h6: y = 4'h7;  4'h7: y = 4'h9;
      4'h8: y = 4'hB;  4'h9: y = 4'h0;  4'hA: y = 4'h3;  4'hB: y = 4'hD;
      4'hC: y = 4'h8;  4'hD: y = 4'hF;  4'hE: y = 4'h4;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = GEN;
        end
      end
      GEN: begin
`ifdef RECTANGLE128_KS_RESTART_EN
        // a fresh request overrides the run in flight, including its last write
        if (start) load = 1'b1;
        else
`endif
        if (cnt == 5'd25) state_nxt = DONE;
        else              step      = 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // S-box layer touches only the low 8 columns; upper bits pass straight through
  always_comb begin
    s0  = r0;
    s1  = r1;
    s2  = r2;
    s3  = r3;
    nib = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      nib   = sbox({r3[j], r2[j], r1[j], r0[j]});
      s0[j] = nib[0];
      s1[j] = nib[1];
      s2[j] = nib[2];
      s3[j] = nib[3];
    end
  end

  always_comb begin
    n0     = ({s0[23:0], s0[31:24]} ^ s1) ^ {27'd0, rc};
    n1     = s2;
    n2     = s3;
    n3     = {s2[15:0], s2[31:16]} ^ s0;
    rc_nxt = {rc[3:0], rc[4] ^ rc[2]};
  end

  always_ff @(posedge Clk or negedge flush) begin
    if (!flush) begin
      state <= IDLE;
      r0    <= '0;
      r1    <= '0;
      r2    <= '0;
      r3    <= '0;
      rc    <= 5'h01;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        r0  <= Key[31:0];
        r1  <= Key[63:32];
        r2  <= Key[95:64];
        r3  <= Key[127:96];
        rc  <= 5'h01;
        cnt <= '0;
      end else begin
        if (step) begin
          r0 <= n0;
          r1 <= n1;
          r2 <= n2;
          r3 <= n3;
          rc <= rc_nxt;
        end
        if (state == GEN) cnt <= cnt + 5'd1;
      end
    end
  end

  always_comb begin
    busy   = (state == GEN);
    WE     = busy;
    done   = (state == DONE);
    WAddr  = busy ? cnt : '0;
    KeyOut = busy ? {r3[15:0], r2[15:0], r1[15:0], r0[15:0]} : '0;
  end

endmodule

// File: tb/tb_rectangle128_keysched.sv
// Directed self-checking bench for rectangle128_keysched; reference subkeys come
// from an independent bit-level model driven by the published round-constant table.
module tb_rectangle128_keysched;

  logic         Clk = 1'b0;
  logic         flush;
  logic         start;
  logic [127:0] Key;
  logic         busy, done, WE;
  logic [4:0]   WAddr;
  logic [63:0]  KeyOut;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [4:0]  wr_addr[$];
  logic [63:0] wr_data[$];
  int          first_we, last_we, done_cnt, done_cyc, last25, gap, start_edge;
  logic [63:0] model_sk[26];

  logic [3:0] SB[16] = '{4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
                         4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2};
  logic [4:0] RC_TAB[25] = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05, 5'h0B, 5'h16,
                             5'h0C, 5'h19, 5'h13, 5'h07, 5'h0F, 5'h1F, 5'h1E, 5'h1C,
                             5'h18, 5'h11, 5'h03, 5'h06, 5'h0D, 5'h1B, 5'h17, 5'h0E,
                             5'h1D};

  rectangle128_keysched dut (
    .Clk    (Clk),
    .flush  (flush),
    .start  (start),
    .Key    (Key),
    .busy   (busy),
    .done   (done),
    .WE     (WE),
    .WAddr  (WAddr),
    .KeyOut (KeyOut)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (WE) begin
      wr_addr.push_back(WAddr);
      wr_data.push_back(KeyOut);
      if (first_we < 0) first_we = cyc;
      last_we = cyc;
      if (WAddr == 5'd0 && last25 >= 0) gap = cyc - last25;
      if (WAddr == 5'd25) last25 = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void build_model(input logic [127:0] k);
    logic [31:0] r[4];
    logic [31:0] t0, t3;
    logic [3:0]  x;
    for (int b = 0; b < 4; b++) r[b] = k[32*b +: 32];
    for (int i = 0; i < 26; i++) begin
      model_sk[i] = {r[3][15:0], r[2][15:0], r[1][15:0], r[0][15:0]};
      if (i < 25) begin
        for (int j = 0; j < 8; j++) begin
          x = SB[{r[3][j], r[2][j], r[1][j], r[0][j]}];
          for (int b = 0; b < 4; b++) r[b][j] = x[b];
        end
        t0 = {r[0][23:0], r[0][31:24]} ^ r[1];
        t3 = {r[2][15:0], r[2][31:16]} ^ r[0];
        t0[4:0] = t0[4:0] ^ RC_TAB[i];
        r[0] = t0;
        r[1] = r[2];
        r[2] = r[3];
        r[3] = t3;
      end
    end
  endfunction

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    first_we = -1;
    last_we  = -1;
    done_cnt = 0;
    done_cyc = -1;
    last25   = -1;
    gap      = -1;
  endtask

  task automatic pulse_start(input logic [127:0] k);
    @(posedge Clk);
    #1 Key = k;
    start      = 1'b1;
    start_edge = cyc + 1;
    @(posedge Clk);
    #1 start = 1'b0;
    Key = ~k;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 60 && done_cnt == 0; i++) @(negedge Clk);
    check({tag, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
    repeat (3) @(negedge Clk);
    check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
  endtask

  task automatic check_run(input logic [127:0] k, input string tag);
    build_model(k);
    check({tag, "_nwr"}, 64'(wr_addr.size()), 64'd26);
    for (int i = 0; i < wr_addr.size() && i < 26; i++) begin
      check($sformatf("%s_a%0d", tag, i), 64'(wr_addr[i]), 64'(i));
      check($sformatf("%s_d%0d", tag, i), wr_data[i], model_sk[i]);
    end
  endtask

  initial begin
    bit found;
    flush = 1'b0;
    start = 1'b0;
    Key   = '0;
    clear_mon();
    start_edge = 0;

    #3;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_we", 64'(WE), 64'd0);
    check("rst_waddr", 64'(WAddr), 64'd0);
    check("rst_keyout", KeyOut, 64'd0);
    @(negedge Clk) flush = 1'b1;

    // zero key: hand values, latency, full model comparison
    clear_mon();
    pulse_start('0);
    wait_done("zero");
    check_run('0, "zero");
    if (wr_data.size() >= 2) begin
      check("zero_sk0_hand", wr_data[0], 64'h0);
      check("zero_sk1_hand", wr_data[1], 64'h0000_0000_00FF_00FE);
    end
    check("zero_first_we_lat", 64'(first_we - start_edge), 64'd0);
    check("zero_done_lat", 64'(done_cyc - start_edge), 64'd26);
    check("zero_we_span", 64'(last_we - first_we), 64'd25);

    // all-ones key
    clear_mon();
    pulse_start({128{1'b1}});
    wait_done("ones");
    check_run({128{1'b1}}, "ones");
    if (wr_data.size() >= 1) check("ones_sk0_hand", wr_data[0], 64'hFFFF_FFFF_FFFF_FFFF);
    check("ones_we_span", 64'(last_we - first_we), 64'd25);

    // arbitrary key
    clear_mon();
    pulse_start(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    wait_done("mix");
    check_run(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, "mix");

    // flush mid-run at WAddr 10
    clear_mon();
    pulse_start(128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge Clk);
      if (WE && WAddr == 5'd10) found = 1'b1;
    end
    check("fl_seen10", 64'(found), 64'd1);
    #1 flush = 1'b0;
    #1;
    check("fl_we", 64'(WE), 64'd0);
    check("fl_busy", 64'(busy), 64'd0);
    check("fl_done", 64'(done), 64'd0);
    #1 flush = 1'b1;
    clear_mon();
    repeat (35) @(negedge Clk);
    check("fl_no_wr", 64'(wr_addr.size()), 64'd0);
    check("fl_no_done", 64'(done_cnt), 64'd0);
    clear_mon();
    pulse_start(128'h1357_9BDF_2468_ACE0_1122_3344_5566_7788);
    wait_done("fl_re");
    check_run(128'h1357_9BDF_2468_ACE0_1122_3344_5566_7788, "fl_re");

    // start re-pulsed at WAddr 5 with a different key
    clear_mon();
    pulse_start(128'hAAAA_5555_AAAA_5555_0F0F_F0F0_3C3C_C3C3);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge Clk);
      if (WE && WAddr == 5'd5) found = 1'b1;
    end
    check("rs_seen5", 64'(found), 64'd1);
    #1 Key = 128'h0BAD_F00D_CAFE_1234_5678_9ABC_DEF0_0001;
    start = 1'b1;
    clear_mon();
    @(posedge Clk);
    #1 start = 1'b0;
    Key = '0;
    wait_done("rs");
`ifdef RECTANGLE128_KS_RESTART_EN
    check_run(128'h0BAD_F00D_CAFE_1234_5678_9ABC_DEF0_0001, "rs_new");
`else
    build_model(128'hAAAA_5555_AAAA_5555_0F0F_F0F0_3C3C_C3C3);
    check("rs_old_nwr", 64'(wr_addr.size()), 64'd20);
    for (int i = 0; i < wr_addr.size() && i < 20; i++) begin
      check($sformatf("rs_old_a%0d", i), 64'(wr_addr[i]), 64'(i + 6));
      check($sformatf("rs_old_d%0d", i), wr_data[i], model_sk[i + 6]);
    end
`endif

    // start held high: back-to-back runs
    clear_mon();
    @(posedge Clk);
    #1 Key = 128'hFEED_FACE_0000_0000_1234_5678_0000_0000;
    start = 1'b1;
    repeat (70) @(negedge Clk);
    #1 start = 1'b0;
    repeat (40) @(negedge Clk);
    check("hold_gap", 64'(gap), 64'd3);
    check("hold_busy_end", 64'(busy), 64'd0);
    if (wr_data.size() >= 2) begin
      build_model(128'hFEED_FACE_0000_0000_1234_5678_0000_0000);
      check("hold_sk1", wr_data[1], model_sk[1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
